// File: rtl/bcd_time_counter.sv
// BCD hh:mm timekeeper with an internal seconds prescaler and minute/hour set buttons.
// Define TWELVE_HOUR_EN to build the 12-hour (12,01..11) variant with a pm flag.
module bcd_time_counter #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       inc_min,
  input  logic       inc_hr,
  output logic       sec_tick,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [3:0] hrs_ones,
  output logic [3:0] hrs_tens,
  output logic       pm
);

  localparam int            PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [5:0]    SEC_MAX = 6'd59;
`ifdef TWELVE_HOUR_EN
  localparam logic [3:0]    HT_RST  = 4'd1;
  localparam logic [3:0]    HO_RST  = 4'd2;
`else
  localparam logic [3:0]    HT_RST  = 4'd0;
  localparam logic [3:0]    HO_RST  = 4'd0;
`endif

  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic          tick_q, tick_d;
  logic [3:0]    mo_q, mo_d, mt_q, mt_d;
  logic [3:0]    ho_q, ho_d, ht_q, ht_d;
  logic [1:0]    min_sync_q, min_sync_d, hr_sync_q, hr_sync_d;
  logic          min_prev_q, min_prev_d, hr_prev_q, hr_prev_d;
`ifdef TWELVE_HOUR_EN
  logic          pm_q, pm_d;
`endif

  logic min_edge, hr_edge, pre_wrap, tick, sec_carry, min_carry, min_step, hr_step;

  // Button synchronizers and previous-sample registers
  always_comb begin
    min_sync_d = {min_sync_q[0], inc_min};
    hr_sync_d  = {hr_sync_q[0], inc_hr};
    min_prev_d = min_sync_q[1];
    hr_prev_d  = hr_sync_q[1];
    min_edge   = min_sync_q[1] & ~min_prev_q;
    hr_edge    = hr_sync_q[1] & ~hr_prev_q;
  end

  // A minute press restarts the second, so it also swallows a coincident tick.
  always_comb begin
    pre_wrap  = run && (presc_q == PRE_MAX);
    tick      = pre_wrap && !min_edge;
    sec_carry = tick && (sec_q == SEC_MAX);
    min_carry = sec_carry && (mt_q == 4'd5) && (mo_q == 4'd9);
    min_step  = min_edge | sec_carry;
    hr_step   = hr_edge | min_carry;
    tick_d    = tick;

    presc_d = presc_q;
    if (min_edge)      presc_d = '0;
    else if (pre_wrap) presc_d = '0;
    else if (run)      presc_d = presc_q + PW'(1);

    sec_d = sec_q;
    if (min_edge)  sec_d = '0;
    else if (tick) sec_d = (sec_q == SEC_MAX) ? 6'd0 : sec_q + 6'd1;
  end

  always_comb begin
    mo_d = mo_q;
    mt_d = mt_q;
    if (min_step) begin
      if (mo_q == 4'd9) begin
        mo_d = 4'd0;
        mt_d = (mt_q == 4'd5) ? 4'd0 : mt_q + 4'd1;
      end else begin
        mo_d = mo_q + 4'd1;
      end
    end
  end

  // A button step and a tick carry landing together still advance the hour only once.
  always_comb begin
    ho_d = ho_q;
    ht_d = ht_q;
`ifdef TWELVE_HOUR_EN
    pm_d = pm_q;
    if (hr_step) begin
      if (ht_q == 4'd1 && ho_q == 4'd2) begin
        ht_d = 4'd0;
        ho_d = 4'd1;
      end else if (ht_q == 4'd1 && ho_q == 4'd1) begin
        ht_d = 4'd1;
        ho_d = 4'd2;
        pm_d = ~pm_q;
      end else if (ho_q == 4'd9) begin
        ht_d = ht_q + 4'd1;
        ho_d = 4'd0;
      end else begin
        ho_d = ho_q + 4'd1;
      end
    end
`else
    if (hr_step) begin
      if (ht_q == 4'd2 && ho_q == 4'd3) begin
        ht_d = 4'd0;
        ho_d = 4'd0;
      end else if (ho_q == 4'd9) begin
        ht_d = ht_q + 4'd1;
        ho_d = 4'd0;
      end else begin
        ho_d = ho_q + 4'd1;
      end
    end
`endif
  end

  // Sync/prev flops preset high: a button already down at reset release must be
  // released and pressed again before it counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      sec_q      <= '0;
      tick_q     <= 1'b0;
      mo_q       <= 4'd0;
      mt_q       <= 4'd0;
      ho_q       <= HO_RST;
      ht_q       <= HT_RST;
      min_sync_q <= 2'b11;
      hr_sync_q  <= 2'b11;
      min_prev_q <= 1'b1;
      hr_prev_q  <= 1'b1;
    end else begin
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      tick_q     <= tick_d;
      mo_q       <= mo_d;
      mt_q       <= mt_d;
      ho_q       <= ho_d;
      ht_q       <= ht_d;
      min_sync_q <= min_sync_d;
      hr_sync_q  <= hr_sync_d;
      min_prev_q <= min_prev_d;
      hr_prev_q  <= hr_prev_d;
    end
  end

`ifdef TWELVE_HOUR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pm_q <= 1'b0;
    else       pm_q <= pm_d;
  end
  assign pm = pm_q;
`else
  assign pm = 1'b0;
`endif

  assign sec_tick = tick_q;
  assign min_ones = mo_q;
  assign min_tens = mt_q;
  assign hrs_ones = ho_q;
  assign hrs_tens = ht_q;

endmodule
